// File: rtl/adder_err_monitor.sv
// Error-statistics engine for a W-bit approximate adder: per-run error count, ED sum and max ED.
// Optional EDSQ_ACC_EN adds sum_ed_sq, the accumulated ED*ED.
module adder_err_monitor #(
  parameter int W         = 16,
  parameter int N_SAMPLES = 1000000,
  localparam int CNT_W    = $clog2(N_SAMPLES + 1),
  localparam int ACC_W    = W + 1 + CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in0,
  input  logic [W-1:0]     in1,
  input  logic [W:0]       out0,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] sample_count,
  output logic [CNT_W-1:0] err_count,
  output logic [ACC_W-1:0] sum_ed,
  output logic [W:0]       max_ed
`ifdef EDSQ_ACC_EN
  ,
  output logic [2*(W+1)+CNT_W-1:0] sum_ed_sq
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  typedef struct packed {
    logic [W:0] exact;
    logic [W:0] approx;
  } s1_t;

  localparam logic [CNT_W-1:0] NS = CNT_W'(N_SAMPLES);

  state_t           state, state_nxt;
  s1_t              s1;
  logic [1:0]       vld_pipe;
  logic [W:0]       ed, ed_c;
  logic [CNT_W-1:0] accepted, acc_nxt;
  logic             xfer, clr;

  assign xfer    = in_valid & in_ready;
  assign clr     = (state != RUN) & start;
  assign acc_nxt = accepted + {{(CNT_W-1){1'b0}}, xfer};

  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else     state <= state_nxt;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (accepted == NS && vld_pipe == 2'b00) state_nxt = DONE;
      DONE:    if (start) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  // in_ready is precomputed from the post-edge count so it never depends on in_valid
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      accepted <= '0;
      in_ready <= 1'b0;
    end else if (clr) begin
      accepted <= '0;
      in_ready <= (NS != '0);
    end else if (state == RUN) begin
      accepted <= acc_nxt;
      in_ready <= (acc_nxt < NS);
    end else begin
      in_ready <= 1'b0;
    end

  always_comb
    ed_c = (s1.exact >= s1.approx) ? s1.exact - s1.approx : s1.approx - s1.exact;

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      vld_pipe <= '0;
      s1       <= '0;
      ed       <= '0;
    end else begin
      vld_pipe <= clr ? 2'b00 : {vld_pipe[0], xfer};
      if (xfer) begin
        s1.exact  <= {1'b0, in0} + {1'b0, in1};
        s1.approx <= out0;
      end
      if (vld_pipe[0]) ed <= ed_c;
    end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sample_count <= '0;
      err_count    <= '0;
      sum_ed       <= '0;
      max_ed       <= '0;
    end else if (clr) begin
      sample_count <= '0;
      err_count    <= '0;
      sum_ed       <= '0;
      max_ed       <= '0;
    end else if (vld_pipe[1]) begin
      sample_count <= sample_count + 1'b1;
      err_count    <= err_count + {{(CNT_W-1){1'b0}}, |ed};
      sum_ed       <= sum_ed + ACC_W'(ed);
      if (ed > max_ed) max_ed <= ed;
    end

`ifdef EDSQ_ACC_EN
  // square is taken from the stage-1 difference so it lines up with ed
  logic [2*W+1:0] ed_sq;

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ed_sq     <= '0;
      sum_ed_sq <= '0;
    end else begin
      if (vld_pipe[0]) ed_sq <= (2*W+2)'(ed_c) * (2*W+2)'(ed_c);
      if (clr)              sum_ed_sq <= '0;
      else if (vld_pipe[1]) sum_ed_sq <= sum_ed_sq + (2*(W+1)+CNT_W)'(ed_sq);
    end
`endif

endmodule

// File: tb/tb_adder_err_monitor.sv
// Randomized self-checking bench for adder_err_monitor against an arithmetic reference model.
module tb_adder_err_monitor;
  localparam int W  = 16;
  localparam int N  = 4;
  localparam int CW = $clog2(N + 1);
  localparam int AW = W + 1 + CW;

  logic          clk = 1'b0, rst = 1'b1, start = 1'b0, in_valid = 1'b0;
  logic          in_ready, busy, done;
  logic [W-1:0]  in0 = '0, in1 = '0;
  logic [W:0]    out0 = '0, max_ed;
  logic [CW-1:0] sample_count, err_count;
  logic [AW-1:0] sum_ed;
`ifdef EDSQ_ACC_EN
  logic [2*(W+1)+CW-1:0] sum_ed_sq;
`endif

  int n_chk = 0, n_pass = 0;
  logic [W-1:0] va[N], vb[N];
  logic [W:0]   vo[N];

  always #5 clk = ~clk;

  adder_err_monitor #(.W(W), .N_SAMPLES(N)) u_dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in0(in0), .in1(in1), .out0(out0), .busy(busy), .done(done),
    .sample_count(sample_count), .err_count(err_count), .sum_ed(sum_ed), .max_ed(max_ed)
`ifdef EDSQ_ACC_EN
    , .sum_ed_sq(sum_ed_sq)
`endif
  );

  task automatic chk(input string tag, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_sc"},  sample_count, 0);
    chk({tag, "_err"}, err_count, 0);
    chk({tag, "_sum"}, sum_ed, 0);
    chk({tag, "_max"}, max_ed, 0);
    chk({tag, "_rdy"}, in_ready, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  task automatic set_vec(input int i, input logic [W-1:0] a, input logic [W-1:0] b, input logic [W:0] o);
    va[i] = a; vb[i] = b; vo[i] = o;
  endtask

  // mode 0: in_valid held high, 1: toggled every other cycle, 2: random
  task automatic run(input int mode, input bit mid_start);
    longint e_sum = 0, e_sq = 0, ex, ap, ed;
    int e_err = 0, e_cnt = 0, idx = 0, cyc = 0, last = 0, hi = 0;
    longint e_max = 0;
    bit rdy;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("clr_sc", sample_count, 0);
    chk("clr_sum", sum_ed, 0);
    chk("clr_max", max_ed, 0);
    chk("rdy_after_start", in_ready, 1);
    chk("busy_run", busy, 1);
    chk("done_low", done, 0);
    while (cyc < 200 && !done) begin
      case (mode)
        0:       in_valid = 1'b1;
        1:       in_valid = (cyc % 2 == 0);
        default: in_valid = 1'($urandom_range(0, 1));
      endcase
      if (idx < N) begin
        in0 = va[idx]; in1 = vb[idx]; out0 = vo[idx];
      end else begin
        in0 = '0; in1 = '0; out0 = '0;
      end
      start = mid_start && (cyc == 2);
      chk("in_ready", in_ready, longint'(idx < N));
      rdy = in_ready;
      if (rdy) hi++;
      @(posedge clk);
      cyc++;
      if (in_valid && rdy) begin
        ex = longint'(in0) + longint'(in1);
        ap = longint'(out0);
        ed = (ex >= ap) ? ex - ap : ap - ex;
        e_cnt++;
        e_sum += ed;
        e_sq  += ed * ed;
        if (ed != 0) e_err++;
        if (ed > e_max) e_max = ed;
        idx++;
        last = cyc;
      end
      #1;
      start = 1'b0;
    end
    in_valid = 1'b0;
    chk("done_seen", done, 1);
    chk("done_latency", cyc - last, 3);
    chk("busy_fall", busy, 0);
    chk("rdy_cycles", hi, (mode == 0) ? N : last);
    chk("sample_count", sample_count, e_cnt);
    chk("err_count", err_count, e_err);
    chk("sum_ed", sum_ed, e_sum);
    chk("max_ed", max_ed, e_max);
`ifdef EDSQ_ACC_EN
    chk("sum_ed_sq", sum_ed_sq, e_sq);
`endif
    tick();
    chk("done_hold", done, 1);
    chk("hold_sum", sum_ed, e_sum);
  endtask

  initial begin
    #2;
    chk_zero("reset");
    tick();
    rst = 1'b0;
    tick();

    // reset in the middle of a run
    for (int i = 0; i < N; i++) set_vec(i, 16'(i + 7), 16'h0003, 17'h1_0000);
    start = 1'b1;
    tick();
    start = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in0 = va[i]; in1 = vb[i]; out0 = vo[i];
      tick();
    end
    tick();
    rst = 1'b1;
    #1;
    chk_zero("midrst");
    in_valid = 1'b0;
    tick();
    chk_zero("midrst_next");
    rst = 1'b0;
    tick();

    // exact approximations
    for (int i = 0; i < N; i++) set_vec(i, 16'h0001, 16'h0002, 17'h0_0003);
    run(0, 1'b0);
    chk("exact_err", err_count, 0);
    chk("exact_sc", sample_count, N);

    // full-range ED, last vector padded with an exact one
    set_vec(0, 16'hFFFF, 16'hFFFF, 17'h0_FFFE);
    set_vec(1, 16'h8000, 16'h8000, 17'h1_0010);
    set_vec(2, 16'h0001, 16'h0001, 17'h0_0002);
    set_vec(3, 16'h0001, 16'h0002, 17'h0_0003);
    run(0, 1'b0);
    chk("c3_err", err_count, 2);
    chk("c3_sum", sum_ed, 'h10010);
    chk("c3_max", max_ed, 'h10000);
`ifdef EDSQ_ACC_EN
    chk("c3_sq", sum_ed_sq, 'h1_0000_0100);
`endif

    // ties and extremes: ED 5,5,0x1FFFE,3
    set_vec(0, 16'h0000, 16'h0000, 17'h0_0005);
    set_vec(1, 16'h0000, 16'h0000, 17'h0_0005);
    set_vec(2, 16'hFFFF, 16'hFFFF, 17'h0_0000);
    set_vec(3, 16'h0001, 16'h0002, 17'h0_0000);
    run(0, 1'b0);
    chk("c4_max", max_ed, 'h1FFFE);
    chk("c4_sum", sum_ed, 'h2000B);
    run(1, 1'b1);
    chk("c4t_max", max_ed, 'h1FFFE);
    chk("c4t_sum", sum_ed, 'h2000B);

    // random vectors and handshake gaps
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < N; i++) begin
        logic [W-1:0] a, b;
        logic [W:0]   s;
        a = 16'($urandom);
        b = 16'($urandom);
        s = {1'b0, a} + {1'b0, b};
        case ($urandom_range(0, 2))
          0:       set_vec(i, a, b, s);
          1:       set_vec(i, a, b, s ^ 17'($urandom_range(1, 255)));
          default: set_vec(i, a, b, 17'($urandom));
        endcase
      end
      run(2, r[0]);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
